uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler that shares the UART transmitter between NREQ byte
//  producers (e.g. CPU console, HW trace logger). Acts as bus master on the
//  UART register port (valid/wstrb/addr/wdata -> ready/rdata). Per byte:
//  poll TX status, load TX data, pulse TX enable. Sits between producers and
//  the uart block; no software involvement per byte.
// PARAMETERS
//  NREQ          2   number of requesters (>=2); one grant at a time
//  BUSY_TIMEOUT  16  max polls of TX status waiting for busy=1 after enable
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, synchronous, active-high
//  req_valid   in   NREQ     requester i has byte; held until req_ready[i]
//  req_data    in   NREQ*8   byte of requester i at [8*i+7:8*i]
//  req_ready   out  NREQ     1-cycle accept pulse; byte captured that cycle
//  m_valid     out  1        UART register access request
//  m_wstrb     out  1        1=write, 0=read
//  m_addr      out  8        UART register address
//  m_wdata     out  16       write data
//  m_ready     in   1        UART access complete (1-cycle pulse)
//  m_rdata     in   16       UART read data, valid while m_ready=1
//  grant_id    out  $clog2(NREQ)  index of requester owning current byte
//  sched_busy  out  1        1 from byte capture until final access done
//  err_timeout out  1        sticky: busy never rose within BUSY_TIMEOUT
//  err_clr     in   1        clears err_timeout (set wins if same cycle)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer last=NREQ-1 (req0 first).
//  - Bus: all m_* registered. m_valid/wstrb/addr/wdata held stable until
//    m_ready=1 sampled; m_valid=0 (and m_wstrb=0) the following cycle; >=1
//    idle cycle between accesses. m_wstrb=1 only while m_valid=1.
//  - Registers: 0x00 TX status (rdata[0]=busy), 0x02 TX enable, 0x04 TX data.
//  - FSM:
//    IDLE: if any req_valid, pick first set bit scanning last+1..last+NREQ
//      (mod NREQ); capture byte, pulse req_ready[g], grant_id<=g, last<=g
//      -> POLL_IDLE. No request -> stay, no bus activity.
//    POLL_IDLE: read 0x00; on m_ready: rdata[0]=0 -> WR_DATA, else reissue.
//    WR_DATA: write 0x04 = {8'h00,byte}; on m_ready -> WR_EN1.
//    WR_EN1: write 0x02 = 16'h0001; on m_ready -> POLL_BUSY, tmo_cnt<=0.
//    POLL_BUSY: read 0x00; on m_ready: rdata[0]=1 -> WR_EN0; else tmo_cnt++;
//      if tmo_cnt reaches BUSY_TIMEOUT-1 -> set err_timeout, -> WR_EN0.
//    WR_EN0: write 0x02 = 16'h0000; on m_ready -> IDLE, sched_busy<=0.
//  - Arbitration only in IDLE; new/withdrawn req_valid mid-byte ignored.
//    req_valid dropped before grant is legal (no capture).
//  - Single requester active: served back-to-back, no idle gap beyond FSM.
//  - m_rdata ignored unless m_ready=1 in a read state.
//  - Reset mid-operation: FSM to IDLE immediately; m_valid=0 next cycle;
//    in-flight byte discarded (already acknowledged to requester).
//  - At most one req_ready bit high per cycle; never while sched_busy=1.
// TESTING
//  - req0=0x41 alone, UART idle -> bus: RD 00, WR 04=0x0041, WR 02=1,
//    RD 00 (busy=1), WR 02=0; req_ready[0] one pulse; txd frames 0x41.
//  - req0,req1 continuously valid (0x10/0x20) -> grants 0,1,0,1 alternate;
//    neither starves over 8 bytes.
//  - UART busy on first poll (model returns busy=1 x3) -> 4 reads of 00
//    before data write; no write to 04 while busy.
//  - Model never returns busy=1 -> exactly BUSY_TIMEOUT reads in POLL_BUSY,
//    err_timeout=1, WR 02=0 still issued; err_clr -> 0 next cycle.
//  - m_ready delayed 5 cycles on WR_DATA -> m_* stable all 5 cycles, one
//    write only; m_valid low cycle after m_ready.
//  - rst asserted in POLL_BUSY -> all outputs 0 next cycle, sched_busy=0,
//    next grant goes to req0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds bytes from NREQ producers into the shared UART transmitter.
// Latency: byte accepted in IDLE, first UART access issued 2 cycles later; each access then waits for m_ready.
// Backpressure: req_ready is offered only in IDLE, so producers wait while a byte is in flight; the bus holds until m_ready.
module uart_tx_sched #(
  parameter int NREQ         = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*8-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     m_valid,
  output logic                     m_wstrb,
  output logic [7:0]               m_addr,
  output logic [15:0]              m_wdata,
  input  logic                     m_ready,
  input  logic [15:0]              m_rdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     sched_busy,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  // UART register map
  localparam logic [7:0] ADDR_STAT = 8'h00;
  localparam logic [7:0] ADDR_EN   = 8'h02;
  localparam logic [7:0] ADDR_DATA = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POLL_IDLE = 3'd1,
    S_WR_DATA   = 3'd2,
    S_WR_EN1    = 3'd3,
    S_POLL_BUSY = 3'd4,
    S_WR_EN0    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [7:0]      byte_q, byte_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            m_valid_q, m_valid_d;
  logic            m_wstrb_q, m_wstrb_d;
  logic [7:0]      m_addr_q, m_addr_d;
  logic [15:0]     m_wdata_q, m_wdata_d;

  // Arbiter results
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  int              idx;
  logic [7:0]      sel_byte;

  // Command for the access belonging to the current state
  logic            cmd_w;
  logic [7:0]      cmd_a;
  logic [15:0]     cmd_d;
  logic            done;
  logic            err_set;

  // Only the busy bit of the status register carries meaning here
  logic            rdata_unused;
  assign rdata_unused = ^m_rdata[15:1];

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Byte of the requester that would win this cycle
  always_comb begin
    sel_byte = 8'h00;
    for (int j = 0; j < NREQ; j++) begin
      if (GW'(j) == pick) sel_byte = req_data[j*8 +: 8];
    end
  end

  // Accept pulse is offered only from IDLE, and never while reset is applied
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = (state_q == S_IDLE) && found && !rst && (GW'(j) == pick);
    end
  end

  // Register access that each bus state performs
  always_comb begin
    cmd_w = 1'b0;
    cmd_a = ADDR_STAT;
    cmd_d = 16'h0000;
    case (state_q)
      S_WR_DATA: begin cmd_w = 1'b1; cmd_a = ADDR_DATA; cmd_d = {8'h00, byte_q}; end
      S_WR_EN1:  begin cmd_w = 1'b1; cmd_a = ADDR_EN;   cmd_d = 16'h0001;        end
      S_WR_EN0:  begin cmd_w = 1'b1; cmd_a = ADDR_EN;   cmd_d = 16'h0000;        end
      default:   begin cmd_w = 1'b0; cmd_a = ADDR_STAT; cmd_d = 16'h0000;        end
    endcase
  end

  assign done = m_valid_q && m_ready;

  // Next-state, bus sequencing and byte capture
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    tmo_d     = tmo_q;
    err_set   = 1'b0;
    m_valid_d = m_valid_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;

    // Every non-IDLE state owns exactly one outstanding access. It is issued
    // when the bus is idle and dropped the cycle after m_ready, which gives
    // the mandatory idle cycle between back-to-back accesses.
    if (state_q != S_IDLE) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_wstrb_d = cmd_w;
        m_addr_d  = cmd_a;
        m_wdata_d = cmd_d;
      end else if (m_ready) begin
        m_valid_d = 1'b0;
        m_wstrb_d = 1'b0;
        m_addr_d  = 8'h00;
        m_wdata_d = 16'h0000;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          byte_d  = sel_byte;
          grant_d = pick;
          last_d  = pick;
          busy_d  = 1'b1;
          state_d = S_POLL_IDLE;
        end
      end
      S_POLL_IDLE: begin
        // Keep polling until the transmitter reports idle
        if (done && !m_rdata[0]) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (done) state_d = S_WR_EN1;
      end
      S_WR_EN1: begin
        if (done) begin
          state_d = S_POLL_BUSY;
          tmo_d   = '0;
        end
      end
      S_POLL_BUSY: begin
        // Wait for the transmitter to pick the byte up; give up after the budget
        if (done) begin
          if (m_rdata[0]) begin
            state_d = S_WR_EN0;
          end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
            err_set = 1'b1;
            state_d = S_WR_EN0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_WR_EN0: begin
        if (done) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_comb begin
    err_d = err_set | (err_q & ~err_clr);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= GW'(NREQ - 1);
      grant_q   <= '0;
      byte_q    <= 8'h00;
      busy_q    <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_wstrb_q <= 1'b0;
      m_addr_q  <= 8'h00;
      m_wdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_wstrb     = m_wstrb_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign grant_id    = grant_q;
  assign sched_busy  = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural UART register responder.
// Stimulus is driven 1 time unit after the rising edge; the responder works on the falling edge.
// Responder latency per access is programmable so the held-request path is exercised.
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int BT   = 16;

  typedef struct packed {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
  } tr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              m_valid, m_wstrb;
  logic [7:0]        m_addr;
  logic [15:0]       m_wdata;
  logic              m_ready;
  logic [15:0]       m_rdata;
  logic [0:0]        grant_id;
  logic              sched_busy, err_timeout, err_clr;

  uart_tx_sched #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .grant_id(grant_id), .sched_busy(sched_busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder configuration (written by the main sequence only)
  int pre_busy   = 0;
  int data_delay = 0;
  bit never_busy = 1'b0;

  // Logs and protocol counters (written by the responder only)
  tr_t             log_q[$];
  logic [NREQ-1:0] grant_q[$];
  int wstrb_err = 0, stab_err = 0, gap_err = 0, rdy_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic tr_t mk(input logic w, input logic [7:0] a, input logic [15:0] d);
    tr_t t;
    t.w = w; t.a = a; t.d = d;
    return t;
  endfunction

  // UART register model plus bus and handshake monitors
  initial begin : responder
    int   wait_cnt;
    int   idle_polls;
    bit   en_seen;
    bit   busy;
    bit   pv_valid, pv_ready;
    tr_t  pv_bus;
    wait_cnt = 0; idle_polls = 0; en_seen = 1'b0; busy = 1'b0;
    pv_valid = 1'b0; pv_ready = 1'b0; pv_bus = '0;
    m_ready = 1'b0;
    m_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (m_wstrb && !m_valid) wstrb_err++;
      if (m_valid && pv_valid && !pv_ready && (mk(m_wstrb, m_addr, m_wdata) != pv_bus)) stab_err++;
      if (m_valid && m_ready) gap_err++;
      if (($countones(req_ready) > 1) || ((req_ready != '0) && sched_busy)) rdy_err++;
      if (req_ready != '0) grant_q.push_back(req_ready);
      pv_valid = m_valid;
      pv_ready = m_ready;
      pv_bus   = mk(m_wstrb, m_addr, m_wdata);
      if (rst) begin
        m_ready = 1'b0; m_rdata = 16'h0000;
        wait_cnt = 0; idle_polls = 0; en_seen = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0; m_rdata = 16'h0000; wait_cnt = 0;
      end else if (m_valid) begin
        if (wait_cnt >= ((m_wstrb && m_addr == 8'h04) ? data_delay : 0)) begin
          m_ready = 1'b1;
          log_q.push_back(mk(m_wstrb, m_addr, m_wdata));
          if (!m_wstrb) begin
            if (en_seen) busy = !never_busy;
            else begin
              busy = (idle_polls < pre_busy);
              idle_polls++;
            end
            // Upper bits carry junk; only bit 0 is the busy flag
            m_rdata = 16'hA5A4 | {15'h0, busy};
          end else if (m_addr == 8'h02) begin
            if (m_wdata[0]) en_seen = 1'b1;
            else begin en_seen = 1'b0; idle_polls = 0; end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int n, input int budget);
    int c = 0;
    while (grant_q.size() < n && c < budget) begin tick(); c++; end
    chk("wait_grant", 32'(grant_q.size() >= n), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin tick(); c++; end
    chk("wait_log", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (sched_busy && c < budget) begin tick(); c++; end
    chk("wait_idle", 32'(sched_busy), 32'd0);
    tick();
  endtask

  initial begin : main
    int   base, gbase, cnt, k;
    tr_t  exp1[5];
    rst = 1'b1; req_valid = '0; req_data = '0; err_clr = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_bus", {7'h0, m_wstrb, m_addr, m_wdata}, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_status", {29'h0, grant_id, sched_busy, err_timeout}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte 0x41 from req0, UART idle
    base = log_q.size(); gbase = grant_q.size();
    req_data[7:0] = 8'h41; req_valid = 2'b01;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    chk("t1_grant_vec", 32'(grant_q[gbase]), 32'h1);
    chk("t1_busy_grant", {30'h0, grant_id, sched_busy}, 32'h1);
    wait_log(base + 5, 200);
    wait_idle(50);
    exp1[0] = mk(1'b0, 8'h00, 16'h0000);
    exp1[1] = mk(1'b1, 8'h04, 16'h0041);
    exp1[2] = mk(1'b1, 8'h02, 16'h0001);
    exp1[3] = mk(1'b0, 8'h00, 16'h0000);
    exp1[4] = mk(1'b1, 8'h02, 16'h0000);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_tr%0d", i), 32'(log_q[base + i]), 32'(exp1[i]));
    chk("t1_log_len", 32'(log_q.size() - base), 32'd5);
    chk("t1_ready_pulses", 32'(grant_q.size() - gbase), 32'd1);

    // Both requesters held: last grant was req0, so req1, req0, ... alternate
    base = log_q.size(); gbase = grant_q.size();
    req_data = {8'h20, 8'h10}; req_valid = 2'b11;
    wait_grant(gbase + 8, 2000);
    req_valid = 2'b00;
    wait_idle(300);
    cnt = 0;
    for (int i = 0; i < 8; i++) if (grant_q[gbase + i] !== ((i % 2 == 0) ? 2'b10 : 2'b01)) cnt++;
    chk("t2_alternation_errs", 32'(cnt), 32'd0);
    cnt = 0; k = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].w && log_q[i].a == 8'h04) begin
        if (log_q[i].d !== ((k % 2 == 0) ? 16'h0020 : 16'h0010)) cnt++;
        k++;
      end
    end
    chk("t2_data_writes", 32'(k), 32'd8);
    chk("t2_data_errs", 32'(cnt), 32'd0);

    // UART busy on the first three polls: four status reads, then the data write
    base = log_q.size(); gbase = grant_q.size();
    pre_busy = 3;
    req_data[15:8] = 8'h5A; req_valid = 2'b10;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    chk("t3_grant_id", 32'(grant_id), 32'd1);
    wait_idle(300);
    pre_busy = 0;
    cnt = 0;
    while (cnt < log_q.size() - base && !log_q[base + cnt].w && log_q[base + cnt].a == 8'h00) cnt++;
    chk("t3_idle_polls", 32'(cnt), 32'd4);
    chk("t3_data_wr", 32'(log_q[base + 4]), 32'(mk(1'b1, 8'h04, 16'h005A)));
    chk("t3_log_len", 32'(log_q.size() - base), 32'd8);

    // Data write held 5 cycles by the UART
    base = log_q.size(); gbase = grant_q.size();
    data_delay = 5;
    req_data[7:0] = 8'h33; req_valid = 2'b01;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    k = 0;
    while (!(m_valid && m_wstrb && m_addr == 8'h04) && k < 100) begin tick(); k++; end
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(m_valid && m_wstrb && m_addr == 8'h04 && m_wdata == 16'h0033)) cnt++;
    end
    chk("t4_held_bus_errs", 32'(cnt), 32'd0);
    tick();
    chk("t4_valid_low_after", 32'(m_valid), 32'd0);
    wait_idle(300);
    data_delay = 0;
    cnt = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].w && log_q[i].a == 8'h04) cnt++;
    chk("t4_single_write", 32'(cnt), 32'd1);

    // Transmitter never reports busy: timeout after exactly BT polls
    base = log_q.size(); gbase = grant_q.size();
    never_busy = 1'b1;
    req_data[15:8] = 8'h77; req_valid = 2'b10;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    wait_idle(600);
    chk("t5_log_len", 32'(log_q.size() - base), 32'd20);
    cnt = 0;
    for (int i = base + 3; i < log_q.size(); i++) if (!log_q[i].w && log_q[i].a == 8'h00) cnt++;
    chk("t5_busy_polls", 32'(cnt), 32'd16);
    chk("t5_last_en0", 32'(log_q[log_q.size() - 1]), 32'(mk(1'b1, 8'h02, 16'h0000)));
    repeat (3) tick();
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_cleared", 32'(err_timeout), 32'd0);

    // Reset while polling for busy; req0 in flight, so req1 would be next without reset
    base = log_q.size(); gbase = grant_q.size();
    req_data[7:0] = 8'h41; req_valid = 2'b01;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    wait_log(base + 4, 200);
    chk("t6_inflight", 32'(sched_busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_m_bus", {7'h0, m_wstrb, m_addr, m_wdata}, 32'd0);
    chk("t6_rst_status", {29'h0, grant_id, sched_busy, err_timeout}, 32'd0);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    never_busy = 1'b0;
    tick();
    gbase = grant_q.size();
    req_data = {8'h20, 8'h10}; req_valid = 2'b11;
    wait_grant(gbase + 1, 50);
    req_valid = 2'b00;
    chk("t6_first_after_rst", 32'(grant_q[gbase]), 32'h1);
    wait_idle(300);

    // Protocol monitors over the whole run
    chk("wstrb_without_valid", 32'(wstrb_err), 32'd0);
    chk("bus_unstable_while_held", 32'(stab_err), 32'd0);
    chk("no_idle_after_ready", 32'(gap_err), 32'd0);
    chk("req_ready_rules", 32'(rdy_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
